ghost_chase_sequencer: RTL and testbench
========================================

# ghost_chase_sequencer

Per-frame ghost movement engine and the sole writer of the ghost coordinate register file. On each `tick` it reads Pac-Man's pixel position, then for each ghost in turn it:
- reads the ghost's position,
- picks a one-step move toward Pac-Man,
- checks the candidate pixel against the maze wall lookup,
- writes the accepted position back.

It drives the register file's `character_type`/`readwrite`/`x_in`/`y_in` and consumes its registered `x_out`/`y_out`.

## Interface
Parameters:
- `NUM_GHOSTS`, 4: ghosts serviced per pass, ids 1..NUM_GHOSTS.
- `STEP`, 1: pixels moved per accepted step.

Ports (clock and reset: clock `clock_50`; reset `reset`, synchronous, active-high):
- `clock_50`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `tick`  in  1  single-cycle move request, sampled only in IDLE.
- `reg_x_out`, `reg_y_out`  in  8 each  register-file read data, valid the cycle after a read is driven.
- `map_wall`  in  1  wall flag for the last query, valid one cycle after `map_qx`/`map_qy` are driven.
- `char_type`  out  3  register-file select (0 = Pac-Man, 1..4 = ghosts).
- `readwrite`  out  1  1 = write to the register file, 0 = read.
- `x_write`, `y_write`  out  8 each  write data to the register file.
- `map_qx`, `map_qy`  out  8 each  candidate pixel sent to the wall lookup.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at the end of a pass.

## Operation
- States: IDLE, RD_PAC, CAP_PAC, RD_G, CAP_G, Q1, W1, Q2, W2, WRITE, DONE.
- IDLE: on `tick`=1, set `g`=1 and go to RD_PAC.
- RD_PAC: drive `char_type`=0, `readwrite`=0.
- CAP_PAC: latch `px`/`py` from `reg_x_out`/`reg_y_out`.
- RD_G: drive `char_type`=`g`, `readwrite`=0.
- CAP_G: latch `gx`/`gy`. Compute `dx`=`px`−`gx` and `dy`=`py`−`gy` as signed 9-bit values.
  - Primary axis is the one with the larger |d|. A tie selects x.
  - Secondary axis is the other one, used only if its d is non-zero.
  - If both d are 0, skip to the next ghost: no query, no write.
- Candidate per axis: move that coordinate by `STEP` toward Pac-Man. If the remaining |d| < `STEP`, clamp the coordinate to Pac-Man's coordinate. The result never wraps and never leaves 0..255.
- Q1: drive `map_qx`/`map_qy` = primary candidate.
- W1: sample `map_wall`.
  - 0: go to WRITE with the primary candidate.
  - 1 and a secondary axis exists: go to Q2.
  - 1 and no secondary axis: skip to the next ghost.
- Q2/W2: same as Q1/W1 using the secondary candidate. A wall here skips the ghost with no write.
- WRITE: drive `readwrite`=1, `char_type`=`g`, `x_write`/`y_write` = accepted position, for exactly one cycle.
- Next ghost:
  - If `g` < NUM_GHOSTS: `g`+1, go to RD_G.
  - Otherwise go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `readwrite` is 1 only in WRITE; 0 in every other state.
- `tick` outside IDLE is ignored and not queued.
- Pac-Man's position is read once per pass. It is never written.

## Timing
- Reset values, all taking effect at the first clock edge with `reset`=1:
  - `char_type`=0, `readwrite`=0, `x_write`=`y_write`=0, `map_qx`=`map_qy`=0, `busy`=0, `done`=0.
  - state=IDLE, `g`=1.
- Reset mid-pass aborts immediately. Any in-progress WRITE is suppressed on the reset cycle.
- All outputs are registered state outputs.
- Read latency: the value driven in RD_x is captured in CAP_x, one cycle later.
- Wall latency: the query driven in Qn is sampled in Wn, one cycle later.
- Cycle numbering: the `tick` sample edge is cycle 0.
  - RD_PAC = 1, CAP_PAC = 2.
  - Ghost 1 with primary free: RD_G = 3, CAP_G = 4, Q1 = 5, W1 = 6, WRITE = 7.
- Per-ghost cost:
  - Primary free: 5 cycles.
  - Secondary accepted: 7 cycles.
  - Both blocked: 6 cycles.
  - Already on Pac-Man: 2 cycles.
- All primary free, NUM_GHOSTS=4: WRITEs at cycles 7, 12, 17, 22; DONE at 23; IDLE at 24.

## Test plan
- Reset: hold `reset` for 2 cycles with `tick` high. All outputs are 0 and no pass starts; the first `tick` after reset release starts RD_PAC on the next cycle.
- Pac-Man at (20,20), ghosts at (40,35), (45,35), (50,35), (55,35), no walls. Single `tick` produces:
  - writes (39,35), (44,35), (49,35), (54,35) at cycles 7, 12, 17, 22;
  - `done` at 23;
  - `busy` high on cycles 1–23.
- Wall at query (39,35) only, same Pac-Man and ghost 1. Ghost 1 queries (39,35) then (40,34), and writes (40,34) at cycle 9.
- Ghost 1 blocked on both axes:
  - no WRITE with `char_type`=1;
  - ghost 2 RD_G at cycle 9;
  - ghost 1 register value unchanged.
- Edge geometry, no walls:
  - ghost 1 at (20,20) equal to Pac-Man: no query, no write.
  - ghost 1 at (25,25) with |dx|=|dy|: moves on x to (24,25).
  - with `STEP`=4 and dx=−2: clamps to Pac-Man's x.
- `tick` pulsed at cycles 5 and 15 during a pass is ignored, with exactly one `done`. Asserting `reset` at cycle 12 gives IDLE and all outputs 0 at cycle 13, and the register file is not written at cycle 12.

Source files
------------

// File: rtl/ghost_chase_sequencer.sv
// ghost_chase_sequencer: per-tick ghost movement engine.
// Steps each ghost one move toward Pac-Man, honouring maze walls.
module ghost_chase_sequencer #(
    parameter int NUM_GHOSTS = 4,
    parameter int STEP       = 1
) (
    input  logic       clock_50,
    input  logic       reset,
    input  logic       tick,
    input  logic [7:0] reg_x_out,
    input  logic [7:0] reg_y_out,
    input  logic       map_wall,
    output logic [2:0] char_type,
    output logic       readwrite,
    output logic [7:0] x_write,
    output logic [7:0] y_write,
    output logic [7:0] map_qx,
    output logic [7:0] map_qy,
    output logic       busy,
    output logic       done
);

    typedef enum logic [3:0] {
        IDLE,
        RD_PAC,
        CAP_PAC,
        RD_G,
        CAP_G,
        Q1,
        W1,
        Q2,
        W2,
        WRITE,
        DONE
    } state_t;

    localparam logic [2:0] LAST_G = 3'(NUM_GHOSTS);
    localparam logic [8:0] STEP9  = 9'(STEP);

    state_t     state_q, state_d;
    logic [2:0] g_q, g_d;
    logic [7:0] px_q, px_d;
    logic [7:0] py_q, py_d;
    logic [7:0] gx_q, gx_d;
    logic [7:0] gy_q, gy_d;
    logic [7:0] c1x_q, c1x_d;
    logic [7:0] c1y_q, c1y_d;
    logic [7:0] c2x_q, c2x_d;
    logic [7:0] c2y_q, c2y_d;
    logic       has2_q, has2_d;

    logic [2:0] ct_q, ct_d;
    logic       rw_q, rw_d;
    logic [7:0] xw_q, xw_d;
    logic [7:0] yw_q, yw_d;
    logic [7:0] qx_q, qx_d;
    logic [7:0] qy_q, qy_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [7:0] cand_x, cand_y;
    logic [7:0] adx, ady;
    logic       x_pri;
    state_t     next_st;
    logic [2:0] next_g;

    // Absolute distance between two unsigned coordinates.
    function automatic logic [7:0] abs_diff(
        input logic [7:0] a,
        input logic [7:0] b
    );
        abs_diff = (a > b) ? (a - b) : (b - a);
    endfunction

    // One step toward p; clamps onto p when closer than STEP.
    function automatic logic [7:0] step_toward(
        input logic [7:0] g,
        input logic [7:0] p
    );
        logic [8:0] mag;
        mag = {1'b0, abs_diff(p, g)};
        if (p == g) begin
            step_toward = g;
        end else if (mag < STEP9) begin
            step_toward = p;
        end else if (p > g) begin
            step_toward = g + STEP9[7:0];
        end else begin
            step_toward = g - STEP9[7:0];
        end
    endfunction

    always_comb begin
        adx    = abs_diff(px_q, reg_x_out);
        ady    = abs_diff(py_q, reg_y_out);
        cand_x = step_toward(reg_x_out, px_q);
        cand_y = step_toward(reg_y_out, py_q);
        x_pri  = (adx >= ady);
    end

    always_comb begin
        next_st = (g_q < LAST_G) ? RD_G : DONE;
        next_g  = (g_q < LAST_G) ? (g_q + 3'd1) : g_q;
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        px_d    = px_q;
        py_d    = py_q;
        gx_d    = gx_q;
        gy_d    = gy_q;
        c1x_d   = c1x_q;
        c1y_d   = c1y_q;
        c2x_d   = c2x_q;
        c2y_d   = c2y_q;
        has2_d  = has2_q;
        ct_d    = ct_q;
        xw_d    = xw_q;
        yw_d    = yw_q;
        qx_d    = qx_q;
        qy_d    = qy_q;

        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = RD_PAC;
                    g_d     = 3'd1;
                end
            end
            RD_PAC: state_d = CAP_PAC;
            CAP_PAC: begin
                px_d    = reg_x_out;
                py_d    = reg_y_out;
                state_d = RD_G;
            end
            RD_G: state_d = CAP_G;
            CAP_G: begin
                gx_d   = reg_x_out;
                gy_d   = reg_y_out;
                c1x_d  = x_pri ? cand_x : reg_x_out;
                c1y_d  = x_pri ? reg_y_out : cand_y;
                c2x_d  = x_pri ? reg_x_out : cand_x;
                c2y_d  = x_pri ? cand_y : reg_y_out;
                has2_d = x_pri ? (ady != 8'd0) : (adx != 8'd0);
                if (adx == 8'd0 && ady == 8'd0) begin
                    state_d = next_st;
                    g_d     = next_g;
                end else begin
                    state_d = Q1;
                end
            end
            Q1: state_d = W1;
            W1: begin
                if (!map_wall) begin
                    state_d = WRITE;
                    xw_d    = c1x_q;
                    yw_d    = c1y_q;
                end else if (has2_q) begin
                    state_d = Q2;
                end else begin
                    state_d = next_st;
                    g_d     = next_g;
                end
            end
            Q2: state_d = W2;
            W2: begin
                if (!map_wall) begin
                    state_d = WRITE;
                    xw_d    = c2x_q;
                    yw_d    = c2y_q;
                end else begin
                    state_d = next_st;
                    g_d     = next_g;
                end
            end
            WRITE: begin
                state_d = next_st;
                g_d     = next_g;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered against the state being entered.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        rw_d   = (state_d == WRITE);
        if (state_d == RD_PAC) begin
            ct_d = 3'd0;
        end
        if (state_d == RD_G || state_d == WRITE) begin
            ct_d = g_d;
        end
        if (state_d == Q1) begin
            qx_d = c1x_d;
            qy_d = c1y_d;
        end
        if (state_d == Q2) begin
            qx_d = c2x_d;
            qy_d = c2y_d;
        end
    end

    always_ff @(posedge clock_50) begin
        if (reset) begin
            state_q <= IDLE;
            g_q     <= 3'd1;
            px_q    <= 8'd0;
            py_q    <= 8'd0;
            gx_q    <= 8'd0;
            gy_q    <= 8'd0;
            c1x_q   <= 8'd0;
            c1y_q   <= 8'd0;
            c2x_q   <= 8'd0;
            c2y_q   <= 8'd0;
            has2_q  <= 1'b0;
            ct_q    <= 3'd0;
            rw_q    <= 1'b0;
            xw_q    <= 8'd0;
            yw_q    <= 8'd0;
            qx_q    <= 8'd0;
            qy_q    <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            px_q    <= px_d;
            py_q    <= py_d;
            gx_q    <= gx_d;
            gy_q    <= gy_d;
            c1x_q   <= c1x_d;
            c1y_q   <= c1y_d;
            c2x_q   <= c2x_d;
            c2y_q   <= c2y_d;
            has2_q  <= has2_d;
            ct_q    <= ct_d;
            rw_q    <= rw_d;
            xw_q    <= xw_d;
            yw_q    <= yw_d;
            qx_q    <= qx_d;
            qy_q    <= qy_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // A reset landing on a WRITE cycle must not reach the register file.
    assign readwrite = rw_q & ~reset;
    assign char_type = ct_q;
    assign x_write   = xw_q;
    assign y_write   = yw_q;
    assign map_qx    = qx_q;
    assign map_qy    = qy_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_ghost_chase_sequencer.sv
// Bench for ghost_chase_sequencer: register-file and wall models,
// pass-level reference model, directed and random passes.
module tb_ghost_chase_sequencer;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       rst;
    logic       tick_v [2];
    logic [7:0] rx_v   [2];
    logic [7:0] ry_v   [2];
    logic       wall_v [2];
    logic [2:0] ct_v   [2];
    logic       rw_v   [2];
    logic [7:0] xw_v   [2];
    logic [7:0] yw_v   [2];
    logic [7:0] qx_v   [2];
    logic [7:0] qy_v   [2];
    logic       busy_v [2];
    logic       done_v [2];

    ghost_chase_sequencer #(.NUM_GHOSTS(4), .STEP(1)) dut (
        .clock_50 (clk),
        .reset    (rst),
        .tick     (tick_v[0]),
        .reg_x_out(rx_v[0]),
        .reg_y_out(ry_v[0]),
        .map_wall (wall_v[0]),
        .char_type(ct_v[0]),
        .readwrite(rw_v[0]),
        .x_write  (xw_v[0]),
        .y_write  (yw_v[0]),
        .map_qx   (qx_v[0]),
        .map_qy   (qy_v[0]),
        .busy     (busy_v[0]),
        .done     (done_v[0])
    );

    ghost_chase_sequencer #(.NUM_GHOSTS(4), .STEP(4)) dut4 (
        .clock_50 (clk),
        .reset    (rst),
        .tick     (tick_v[1]),
        .reg_x_out(rx_v[1]),
        .reg_y_out(ry_v[1]),
        .map_wall (wall_v[1]),
        .char_type(ct_v[1]),
        .readwrite(rw_v[1]),
        .x_write  (xw_v[1]),
        .y_write  (yw_v[1]),
        .map_qx   (qx_v[1]),
        .map_qy   (qy_v[1]),
        .busy     (busy_v[1]),
        .done     (done_v[1])
    );

    // Register file and wall map models
    logic [7:0] rfx [2][8];
    logic [7:0] rfy [2][8];
    logic       load_en = 1'b0;
    int         ld_s;
    logic [7:0] ld_x [8];
    logic [7:0] ld_y [8];
    int         walls [$];

    function automatic bit is_wall(input int s, input int x, input int y);
        foreach (walls[i]) begin
            if (walls[i] == s * 65536 + x * 256 + y) return 1'b1;
        end
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (rw_v[s]) begin
                rfx[s][ct_v[s]] <= xw_v[s];
                rfy[s][ct_v[s]] <= yw_v[s];
            end
            rx_v[s]   <= rfx[s][ct_v[s]];
            ry_v[s]   <= rfy[s][ct_v[s]];
            wall_v[s] <= is_wall(s, int'(qx_v[s]), int'(qy_v[s]));
        end
        if (load_en) begin
            for (int i = 0; i < 8; i++) begin
                rfx[ld_s][i] <= ld_x[i];
                rfy[ld_s][i] <= ld_y[i];
            end
        end
    end

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pass stimulus and observation state
    int pac_x, pac_y;
    int g_x [4];
    int g_y [4];
    int qx_h [128];
    int qy_h [128];
    int ct_h [128];
    int last_done;

    function automatic int absi(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int step_to(input int g, input int p, input int st);
        int d;
        d = p - g;
        if (d == 0) return g;
        if (absi(d) < st) return p;
        return (d > 0) ? g + st : g - st;
    endfunction

    function automatic int pk(input int c, input int id, input int x,
                              input int y);
        return (c << 19) | (id << 16) | (x << 8) | y;
    endfunction

    task automatic run_pass(input int s, input bit extra_tick,
                            input int rst_at);
        int exp_w [$];
        int obs_w [$];
        int fin_x [5];
        int fin_y [5];
        int t, st, dx, dy, cx, cy, ax, ay, bx, by, exp_done, busy_err;
        bit xpri, sec;

        // Preload the register file
        ld_s = s;
        for (int i = 0; i < 8; i++) begin
            ld_x[i] = 8'(i >= 1 && i <= 4 ? g_x[i-1] : 0);
            ld_y[i] = 8'(i >= 1 && i <= 4 ? g_y[i-1] : 0);
        end
        ld_x[0] = 8'(pac_x);
        ld_y[0] = 8'(pac_y);
        @(negedge clk);
        load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0;

        // Reference: per-ghost outcome and cycle cost
        st = (s == 0) ? 1 : 4;
        t  = 2;
        for (int g = 1; g <= 4; g++) begin
            fin_x[g] = g_x[g-1];
            fin_y[g] = g_y[g-1];
            dx = pac_x - g_x[g-1];
            dy = pac_y - g_y[g-1];
            if (dx == 0 && dy == 0) begin
                t += 2;
                continue;
            end
            cx   = step_to(g_x[g-1], pac_x, st);
            cy   = step_to(g_y[g-1], pac_y, st);
            xpri = absi(dx) >= absi(dy);
            ax   = xpri ? cx : g_x[g-1];
            ay   = xpri ? g_y[g-1] : cy;
            bx   = xpri ? g_x[g-1] : cx;
            by   = xpri ? cy : g_y[g-1];
            sec  = xpri ? (dy != 0) : (dx != 0);
            if (!is_wall(s, ax, ay)) begin
                exp_w.push_back(pk(t + 5, g, ax, ay));
                fin_x[g] = ax;
                fin_y[g] = ay;
                t += 5;
            end else if (sec && !is_wall(s, bx, by)) begin
                exp_w.push_back(pk(t + 7, g, bx, by));
                fin_x[g] = bx;
                fin_y[g] = by;
                t += 7;
            end else begin
                t += sec ? 6 : 4;
            end
        end
        exp_done = t + 1;

        tick_v[s] = 1'b1;
        @(posedge clk);
        #1 tick_v[s] = 1'b0;

        last_done = -1;
        busy_err  = 0;
        for (int k = 1; k < 100; k++) begin
            @(negedge clk);
            tick_v[s] = extra_tick && (k == 5 || k == 15);
            if (k == rst_at) begin
                rst = 1'b1;
                #1;
                chk("rst_write_suppressed", 32'(rw_v[s]), 0);
                @(negedge clk);
                chk("rst_ctrl_zero",
                    32'({ct_v[s], rw_v[s], busy_v[s], done_v[s]}), 0);
                chk("rst_data_zero",
                    {xw_v[s], yw_v[s], qx_v[s], qy_v[s]}, 0);
                rst = 1'b0;
                chk("rst_g2_x_kept", 32'(rfx[s][2]), g_x[1]);
                chk("rst_g1_x_moved", 32'(rfx[s][1]), fin_x[1]);
                return;
            end
            qx_h[k] = int'(qx_v[s]);
            qy_h[k] = int'(qy_v[s]);
            ct_h[k] = int'(ct_v[s]);
            if (busy_v[s] !== 1'b1) busy_err++;
            if (rw_v[s]) begin
                obs_w.push_back(pk(k, int'(ct_v[s]), int'(xw_v[s]),
                                   int'(yw_v[s])));
            end
            if (done_v[s]) begin
                last_done = k;
                break;
            end
        end
        tick_v[s] = 1'b0;

        chk("done_cycle", last_done, exp_done);
        chk("busy_through_pass", busy_err, 0);
        chk("write_count", obs_w.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) begin
            chk("write_cycle_id_xy", obs_w[i], exp_w[i]);
        end
        @(negedge clk);
        chk("idle_after_done", 32'({busy_v[s], done_v[s]}), 0);
        for (int g = 1; g <= 4; g++) begin
            chk("rf_ghost_pos", {rfx[s][g], rfy[s][g]},
                32'((fin_x[g] << 8) | fin_y[g]));
        end
        if (extra_tick) begin
            busy_err = 0;
            repeat (6) begin
                @(negedge clk);
                if (busy_v[s] !== 1'b0 || done_v[s] !== 1'b0) busy_err++;
            end
            chk("ignored_tick_no_pass", busy_err, 0);
        end
    endtask

    task automatic set_ghosts(input int a0, input int b0, input int a1,
                              input int b1, input int a2, input int b2,
                              input int a3, input int b3);
        g_x[0] = a0; g_y[0] = b0;
        g_x[1] = a1; g_y[1] = b1;
        g_x[2] = a2; g_y[2] = b2;
        g_x[3] = a3; g_y[3] = b3;
    endtask

    initial begin
        int base, bad;
        rst       = 1'b1;
        tick_v[0] = 1'b1;
        tick_v[1] = 1'b1;

        // Reset held two cycles with tick high
        repeat (2) begin
            @(negedge clk);
            chk("reset_ctrl",
                32'({ct_v[0], rw_v[0], busy_v[0], done_v[0]}), 0);
            chk("reset_data", {xw_v[0], yw_v[0], qx_v[0], qy_v[0]}, 0);
        end
        rst       = 1'b0;
        tick_v[0] = 1'b0;
        tick_v[1] = 1'b0;
        @(negedge clk);
        chk("no_pass_after_reset", 32'({busy_v[0], busy_v[1]}), 0);

        // Baseline: all primary moves free
        pac_x = 20; pac_y = 20;
        set_ghosts(40, 35, 45, 35, 50, 35, 55, 35);
        walls.delete();
        run_pass(0, 1'b0, 0);
        chk("baseline_done_at_23", last_done, 23);
        chk("baseline_rd_pac_ct", ct_h[1], 0);

        // Primary blocked, secondary accepted
        walls.push_back(39 * 256 + 35);
        run_pass(0, 1'b0, 0);
        chk("q1_xy", (qx_h[5] << 8) | qy_h[5], (39 << 8) | 35);
        chk("q2_xy", (qx_h[7] << 8) | qy_h[7], (40 << 8) | 34);

        // Both axes blocked for ghost 1
        walls.push_back(40 * 256 + 34);
        run_pass(0, 1'b0, 0);
        chk("g2_rd_at_9", ct_h[9], 2);

        // Edge geometry: on Pac-Man, tie, ordinary
        walls.delete();
        set_ghosts(20, 20, 25, 25, 0, 255, 255, 0);
        run_pass(0, 1'b0, 0);

        // Clamp with STEP=4
        set_ghosts(22, 21, 30, 20, 20, 20, 10, 12);
        run_pass(1, 1'b0, 0);

        // Ticks during a pass are dropped
        set_ghosts(40, 35, 45, 35, 50, 35, 55, 35);
        run_pass(0, 1'b1, 0);

        // Reset lands on ghost 2's WRITE cycle
        run_pass(0, 1'b0, 12);
        @(negedge clk);

        // Random passes near the middle and the edges of the field
        for (int n = 0; n < 24; n++) begin
            base = (n % 3 == 0) ? 0 : ((n % 3 == 1) ? 240 : 100);
            pac_x = base + $urandom_range(0, 15);
            pac_y = base + $urandom_range(0, 15);
            for (int g = 0; g < 4; g++) begin
                g_x[g] = base + $urandom_range(0, 15);
                g_y[g] = base + $urandom_range(0, 15);
            end
            walls.delete();
            repeat ($urandom_range(0, 60)) begin
                walls.push_back((n % 2) * 65536 +
                                (base + $urandom_range(0, 15)) * 256 +
                                base + $urandom_range(0, 15));
            end
            run_pass(n % 2, 1'b0, 0);
        end

        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (busy_v[0] !== 1'b0 || busy_v[1] !== 1'b0) bad++;
        end
        chk("final_idle", bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
